// File: rtl/output_deskew_collector_if.sv
// Output handshake bundle of the deskew collector.
// The collector drives the aligned row; writeback returns ready.
interface output_deskew_collector_if #(
  parameter int SA_SIZE  = 8,
  parameter int ACC_SIZE = 32
);
  logic [SA_SIZE-1:0][ACC_SIZE-1:0] out_data;
  logic                             out_valid;
  logic                             out_ready;
  logic                             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/output_deskew_collector.sv
// Deskews systolic column results into rows, buffers them in a FWFT
// FIFO and drains them to writeback with tile-last and sticky errors.
module output_deskew_collector #(
  parameter int SA_SIZE    = 8,
  parameter int ACC_SIZE   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TILE_ROWS  = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [SA_SIZE-1:0][ACC_SIZE-1:0] in_data_i,
  input  logic [SA_SIZE-1:0]               in_valid_i,
  input  logic                             err_clear_i,
  output_deskew_collector_if.master        out_if,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count_o,
  output logic                             overflow_err_o,
  output logic                             align_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  typedef logic [SA_SIZE-1:0][ACC_SIZE-1:0] row_t;

  logic [SA_SIZE-1:0] al_v;
  row_t               al_d;

  // Column c waits SA_SIZE-c stages so every column exits together.
  for (genvar c = 0; c < SA_SIZE; c++) begin : g_col
    localparam int N = SA_SIZE - c;
    logic [N-1:0][ACC_SIZE:0] ch_q;

    always_ff @(posedge clk) begin
      if (!resetn) begin
        ch_q <= '0;
      end else begin
        ch_q[0] <= {in_valid_i[c], in_data_i[c]};
        for (int k = 1; k < N; k++) begin
          ch_q[k] <= ch_q[k-1];
        end
      end
    end

    assign al_v[c] = ch_q[N-1][ACC_SIZE];
    assign al_d[c] = ch_q[N-1][ACC_SIZE-1:0];
  end

  row_t           mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  rc_q, rc_d;
  logic           ovf_q, ovf_d;
  logic           aln_q, aln_d;

  logic av, mis, full, pop, push, drop;

  assign av   = al_v[0];
  assign mis  = |(al_v ^ {SA_SIZE{av}});
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  assign pop  = (cnt_q != '0) && out_if.out_ready;
  assign push = av && (!full || pop);
  assign drop = av && full && !pop;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    rc_d  = rc_q;
    if (push) wp_d = wp_q + AW'(1);
    if (pop) begin
      rp_d = rp_q + AW'(1);
      rc_d = (rc_q == RW'(TILE_ROWS - 1)) ? '0 : rc_q + RW'(1);
    end
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);
    // A set event outranks a coincident clear.
    ovf_d = drop ? 1'b1 : (err_clear_i ? 1'b0 : ovf_q);
    aln_d = mis  ? 1'b1 : (err_clear_i ? 1'b0 : aln_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      rc_q  <= '0;
      ovf_q <= 1'b0;
      aln_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      rc_q  <= rc_d;
      ovf_q <= ovf_d;
      aln_q <= aln_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= al_d;
  end

  assign out_if.out_data  = mem_q[rp_q];
  assign out_if.out_valid = (cnt_q != '0);
  assign out_if.out_last  = (cnt_q != '0) &&
                            (rc_q == RW'(TILE_ROWS - 1));
  assign fifo_count_o     = cnt_q;
  assign overflow_err_o   = ovf_q;
  assign align_err_o      = aln_q;

endmodule

// File: doc/output_deskew_collector.md
Name: output_deskew_collector

Overview:
- Receives the column outputs of the systolic array. Column c's result for a given row arrives c cycles after column 0's.
- Each column passes through a per-column delay line so that all columns of one row line up in the same cycle.
- Aligned rows are written into a small first-word-fall-through (FWFT) FIFO and drained over a valid/ready interface to the writeback logic.
- The block flags tile boundaries and sticky protocol errors.

Parameters:
- SA_SIZE, 8, number of array columns.
- ACC_SIZE, 32, width of one column result in bits.
- FIFO_DEPTH, 4, number of aligned rows buffered; power of two, at least 2.
- TILE_ROWS, 8, number of rows per output tile; used to generate out_last.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_data  in  ACC_SIZE x [SA_SIZE]  skewed column results
- in_valid  in  SA_SIZE  per-column valid, skewed the same way as in_data
- err_clear  in  1  single-cycle pulse; clears the sticky error flags
- out_data  out  ACC_SIZE x [SA_SIZE]  aligned row at the FIFO head
- out_valid  out  1  FIFO is not empty
- out_ready  in  1  consumer accepts the head row
- out_last  out  1  head row is the last row of a tile
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow_err  out  1  sticky: an aligned row was dropped
- align_err  out  1  sticky: aligned valid bits disagreed

Behaviour:
- Interface: reset resetn, synchronous, active-low; clock clk.
- Reset: all delay-line registers (data and valid), FIFO pointers, occupancy and row counter go to 0. out_valid=0, out_last=0, fifo_count=0, overflow_err=0, align_err=0. Output data is don't-care while out_valid=0.
- Reset mid-operation discards all in-flight and buffered rows. No output appears until new input arrives.
- Deskew:
  - Column c uses a register chain of SA_SIZE-c stages, carrying {valid, data}.
  - Every column has at least one register stage. The chain advances unconditionally every cycle; the array cannot stall.
  - If column 0 is sampled at edge E0 and column c at edge E0+c, then all columns appear at their chain outputs after edge E0+SA_SIZE-1.
- Aligned valid: av = chain output valid of column 0.
  - If any column's chain-output valid differs from av, set align_err.
  - The push still follows av; data is taken as-is from every column.
- Push: at an edge where av=1.
  - If the FIFO is not full, or a pop happens in the same cycle, the row is written.
  - Otherwise the row is dropped, overflow_err is set and FIFO contents are unchanged.
- Pop: at an edge where out_valid=1 and out_ready=1.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - Allowed when full.
  - When empty, no pop can occur (no bypass); only the push takes effect.
- FWFT output: out_data is the head entry. out_valid = (count != 0).
  - Latency: out_valid rises in the cycle after edge E0+SA_SIZE, i.e. SA_SIZE+1 edges after column 0 is sampled, when the FIFO was empty.
  - out_data and out_last must stay stable while out_valid=1 and out_ready=0.
- Row counter: 0..TILE_ROWS-1.
  - Increments on each pop and wraps to 0 after popping the row where it equals TILE_ROWS-1.
  - out_last = out_valid and (row counter == TILE_ROWS-1).
  - Dropped rows do not advance the counter.
- Sticky errors:
  - Cleared by reset or by err_clear.
  - If a set event and err_clear occur in the same cycle, the set wins and the flag stays 1.
- Full sustained throughput: one row per cycle, provided out_ready is held at 1.

Test Plan (SA_SIZE=4, ACC_SIZE=32, FIFO_DEPTH=4, TILE_ROWS=4):
1. Single row, out_ready=1: drive column c with value 0x10+c, valid in cycle c (c=0..3). Required: out_valid high for exactly 1 cycle, 5 edges after column 0 is sampled; out_data={0x10,0x11,0x12,0x13}; out_last=0.
2. Streaming, out_ready=1: 8 consecutive skewed rows, row k column c = 0x100*k+c. Required: 8 back-to-back out_valid cycles in order; out_last on rows 3 and 7; no errors; fifo_count never exceeds 1.
3. Backpressure: out_ready=0 while 4 rows arrive. Required: fifo_count=4 and head data = row 0 held stable. A 5th row then sets overflow_err and is dropped. After out_ready=1, exactly rows 0..3 drain in order.
4. Push and pop when full: FIFO full; set out_ready=1 in the same cycle a new row aligns. Required: fifo_count stays 4, overflow_err stays 0, the new row is delivered after the existing rows.
5. Misalignment: column 2 valid asserted one cycle late. Required: align_err=1 while the row is still pushed. Asserting err_clear alone clears align_err. err_clear coinciding with a new misalignment leaves align_err=1.
6. Mid-operation reset: assert resetn=0 for 1 cycle with 2 rows buffered and 1 row in flight. Required: out_valid=0, fifo_count=0, errors=0, no stale rows appear afterwards, row counter restarts at 0.
